// File: rtl/irq_trap_ctrl_pkg.sv
// Shared state encodings and CSR bit positions for the trap/interrupt sequencer.
package irq_trap_ctrl_pkg;

    typedef enum logic [1:0] {
        ZCRV_TCTL_RUN   = 2'd0,
        ZCRV_TCTL_FLUSH = 2'd1,
        ZCRV_TCTL_HOLD  = 2'd2,
        ZCRV_TCTL_SLEEP = 2'd3
    } tctl_state_e;

    localparam int ZCRV_MIE_MEIE    = 11;
    localparam int ZCRV_MIE_MTIE    = 7;
    localparam int ZCRV_MIE_MSIE    = 3;
    localparam int ZCRV_MSTATUS_MIE = 3;

endpackage

// File: rtl/irq_trap_ctrl_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-high clear.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= '0;
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/irq_trap_ctrl.sv
// Interrupt/trap sequencer for write-back: sync, arbitrate, flush holdoff and WFI sleep.
// Optional sleep timeout is built when ZCRV_WFI_TIMEOUT_EN is defined.
module irq_trap_ctrl
    import irq_trap_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF_CYC = 2,
    parameter int WFI_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_irq,
    input  logic        time_irq,
    input  logic        soft_irq,
    input  logic [31:0] mie_r,
    input  logic [31:0] mstatus_r,
    input  logic        inst_valid_from_idex,
    input  logic        wfi_from_idex,
    input  logic        trap_en,
    input  logic        trap_return,
    input  logic        flush_done,
    output logic        ext_irq_to_eiu,
    output logic        time_irq_to_eiu,
    output logic        soft_irq_to_eiu,
    output logic        stall_to_pipe,
    output logic        sleep,
    output logic [2:0]  irq_pending
);

    logic [2:0]  irq_raw;
    logic [2:0]  en;
    logic        any_en;
    tctl_state_e state;
    logic [3:0]  hold_cnt;
    logic        wake;

    assign irq_raw = {ext_irq, time_irq, soft_irq};

    for (genvar g = 0; g < 3; g++) begin : g_sync
        irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (irq_raw[g]),
            .q   (irq_pending[g])
        );
    end

    assign en     = irq_pending & {mie_r[ZCRV_MIE_MEIE], mie_r[ZCRV_MIE_MTIE], mie_r[ZCRV_MIE_MSIE]};
    assign any_en = |en;

`ifdef ZCRV_WFI_TIMEOUT_EN
    logic [15:0] sleep_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          sleep_cnt <= '0;
        else if (state != ZCRV_TCTL_SLEEP) sleep_cnt <= '0;
        else                              sleep_cnt <= sleep_cnt + 16'd1;
    end

    assign wake = any_en || (sleep_cnt == 16'(WFI_TIMEOUT - 1));
`else
    localparam int unused_wfi_timeout = WFI_TIMEOUT;
    assign wake = any_en;
`endif

    // stall/sleep are flopped alongside the state so they never glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ZCRV_TCTL_RUN;
            hold_cnt      <= '0;
            stall_to_pipe <= 1'b0;
            sleep         <= 1'b0;
        end else begin
            case (state)
                ZCRV_TCTL_RUN: begin
                    if (trap_en || trap_return) begin
                        state         <= ZCRV_TCTL_FLUSH;
                        stall_to_pipe <= 1'b1;
                    end else if (wfi_from_idex) begin
                        state         <= ZCRV_TCTL_SLEEP;
                        stall_to_pipe <= 1'b1;
                        sleep         <= 1'b1;
                    end
                end
                ZCRV_TCTL_FLUSH: begin
                    if (flush_done) begin
                        stall_to_pipe <= 1'b0;
                        hold_cnt      <= 4'(HOLDOFF_CYC);
                        state         <= (HOLDOFF_CYC == 0) ? ZCRV_TCTL_RUN : ZCRV_TCTL_HOLD;
                    end
                end
                ZCRV_TCTL_HOLD: begin
                    if (hold_cnt <= 4'd1) begin
                        hold_cnt <= '0;
                        state    <= ZCRV_TCTL_RUN;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                ZCRV_TCTL_SLEEP: begin
                    // wake ignores mstatus.MIE; with MIE clear the core just resumes past the WFI
                    if (wake) begin
                        state         <= ZCRV_TCTL_RUN;
                        stall_to_pipe <= 1'b0;
                        sleep         <= 1'b0;
                    end
                end
                default: state <= ZCRV_TCTL_RUN;
            endcase
        end
    end

    // eiu samples these in the same cycle, so no flop on this path
    always_comb begin
        ext_irq_to_eiu  = 1'b0;
        time_irq_to_eiu = 1'b0;
        soft_irq_to_eiu = 1'b0;
        if (state == ZCRV_TCTL_RUN && mstatus_r[ZCRV_MSTATUS_MIE] && inst_valid_from_idex && any_en) begin
            if (en[2])      ext_irq_to_eiu  = 1'b1;
            else if (en[0]) soft_irq_to_eiu = 1'b1;
            else            time_irq_to_eiu = 1'b1;
        end
    end

    logic unused_csr_bits;
    assign unused_csr_bits = ^{mie_r, mstatus_r};

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Scoreboard bench for irq_trap_ctrl: directed scenarios plus random traffic vs a behavioural model.
module tb_irq_trap_ctrl;

    localparam int SYNC = 2;
    localparam int HOLD = 2;
    localparam int WTO  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ext_irq = 0, time_irq = 0, soft_irq = 0;
    logic [31:0] mie_r = '0, mstatus_r = '0;
    logic        inst_valid = 0, wfi = 0, trap_en = 0, trap_return = 0, flush_done = 0;
    logic        ext_o, time_o, soft_o, stall_o, sleep_o;
    logic [2:0]  pend_o;

    irq_trap_ctrl #(.SYNC_STAGES(SYNC), .HOLDOFF_CYC(HOLD), .WFI_TIMEOUT(WTO)) dut (
        .clk(clk), .rst(rst),
        .ext_irq(ext_irq), .time_irq(time_irq), .soft_irq(soft_irq),
        .mie_r(mie_r), .mstatus_r(mstatus_r),
        .inst_valid_from_idex(inst_valid), .wfi_from_idex(wfi),
        .trap_en(trap_en), .trap_return(trap_return), .flush_done(flush_done),
        .ext_irq_to_eiu(ext_o), .time_irq_to_eiu(time_o), .soft_irq_to_eiu(soft_o),
        .stall_to_pipe(stall_o), .sleep(sleep_o), .irq_pending(pend_o)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    int total = 0, bad = 0;

    // Model: input history, plus "what is the core doing" flags and remaining masked cycles.
    logic [2:0] hist[SYNC];
    bit flushing, asleep;
    int hold_left, slept;

    function automatic logic [7:0] model_out();
        logic [2:0] p, e, req;
        p = hist[SYNC-1];
        e = p & {mie_r[11], mie_r[7], mie_r[3]};
        req = 3'b000;
        if (!flushing && !asleep && hold_left == 0 && mstatus_r[3] && inst_valid && e != 0)
            req = e[2] ? 3'b100 : (e[0] ? 3'b001 : 3'b010);
        return {req, flushing | asleep, asleep, p};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < SYNC; i++) hist[i] = '0;
        flushing = 0; asleep = 0; hold_left = 0; slept = 0;
    endtask

    task automatic model_edge();
        logic [2:0] e;
        e = hist[SYNC-1] & {mie_r[11], mie_r[7], mie_r[3]};
        if (flushing) begin
            if (flush_done) begin flushing = 0; hold_left = HOLD; end
        end else if (hold_left > 0) begin
            hold_left--;
        end else if (asleep) begin
            slept++;
            if (e != 0) asleep = 0;
`ifdef ZCRV_WFI_TIMEOUT_EN
            if (slept >= WTO) asleep = 0;
`endif
        end else if (trap_en || trap_return) begin
            flushing = 1;
        end else if (wfi) begin
            asleep = 1; slept = 0;
        end
        for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {ext_irq, time_irq, soft_irq};
    endtask

    // Called at posedge+1: apply inputs for this cycle, queue the expectation, then advance.
    task automatic cyc(input logic [2:0] irqs, input logic [31:0] mie, input logic mst,
                       input logic iv, input logic w, input logic te, input logic tr, input logic fd);
        {ext_irq, time_irq, soft_irq} = irqs;
        mie_r = mie; mstatus_r = {28'd0, mst, 3'd0};
        inst_valid = iv; wfi = w; trap_en = te; trap_return = tr; flush_done = fd;
        exp_q.push_back(model_out());
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n, input logic [2:0] irqs, input logic [31:0] mie, input logic mst);
        for (int i = 0; i < n; i++) cyc(irqs, mie, mst, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        total++;
        if ({ext_o, time_o, soft_o, stall_o, sleep_o, pend_o} !== 8'h00) begin
            bad++;
            $display("FAIL reset_%s got=%b exp=00000000", tag, {ext_o, time_o, soft_o, stall_o, sleep_o, pend_o});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [7:0] e, g;
            e = exp_q.pop_front();
            g = {ext_o, time_o, soft_o, stall_o, sleep_o, pend_o};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL outs t=%0t got={req=%b stall=%b sleep=%b pend=%b} exp={req=%b stall=%b sleep=%b pend=%b}",
                         $time, g[7:5], g[4], g[3], g[2:0], e[7:5], e[4], e[3], e[2:0]);
            end
        end
    end

    initial begin
        model_clear();
        #1;
        total++;
        if ({ext_o, time_o, soft_o, stall_o, sleep_o, pend_o} !== 8'h00) begin
            bad++;
            $display("FAIL reset_init got=%b exp=00000000", {ext_o, time_o, soft_o, stall_o, sleep_o, pend_o});
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // arbitration: ext wins, then soft over time
        idle(4, 3'b111, 32'h888, 1'b1);
        idle(4, 3'b011, 32'h888, 1'b1);
        idle(4, 3'b010, 32'h888, 1'b1);

        // trap then flush_done three cycles later; requests held off afterwards
        cyc(3'b111, 32'h888, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2, 3'b111, 32'h888, 1'b1);
        cyc(3'b111, 32'h888, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(4, 3'b111, 32'h888, 1'b1);

        // mret with an irq pending, zero-length FLUSH wait
        cyc(3'b100, 32'h888, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(3'b100, 32'h888, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(4, 3'b100, 32'h888, 1'b1);

        // WFI with MIE=0: time irq wakes without a request
        idle(3, 3'b000, 32'h080, 1'b0);
        cyc(3'b000, 32'h080, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3, 3'b000, 32'h080, 1'b0);
        idle(5, 3'b010, 32'h080, 1'b0);

        // WFI with everything masked: only the optional timeout wakes it
        idle(3, 3'b100, 32'h000, 1'b1);
        cyc(3'b100, 32'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(12, 3'b100, 32'h000, 1'b1);
        idle(3, 3'b100, 32'h800, 1'b1);

        // trap and WFI together: trap wins
        cyc(3'b000, 32'h888, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2, 3'b000, 32'h888, 1'b1);
        cyc(3'b000, 32'h888, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3, 3'b000, 32'h888, 1'b1);

        // reset while in HOLD
        idle(3, 3'b111, 32'h888, 1'b1);
        cyc(3'b111, 32'h888, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(3'b111, 32'h888, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(3'b111, 32'h888, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset("hold");
        idle(4, 3'b111, 32'h888, 1'b1);

        // reset while asleep
        cyc(3'b111, 32'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2, 3'b111, 32'h000, 1'b1);
        do_reset("sleep");
        idle(3, 3'b000, 32'h888, 1'b1);

        // random traffic
        begin
            logic [2:0]  irqs = 3'b000;
            logic [31:0] mie  = 32'h888;
            for (int n = 0; n < 3000; n++) begin
                for (int b = 0; b < 3; b++)
                    if ($urandom_range(15) == 0) irqs[b] = ~irqs[b];
                if ($urandom_range(31) == 0) mie = $urandom & 32'h888;
                cyc(irqs, mie, 1'($urandom_range(3) != 0), 1'($urandom_range(3) != 0),
                    1'($urandom_range(19) == 0), 1'($urandom_range(15) == 0),
                    1'($urandom_range(19) == 0), 1'($urandom_range(3) == 0));
            end
        end

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
